// File: rtl/dma_streamer.sv
// dma_streamer: turns one linear descriptor into AXI4 INCR burst requests.
// Unaligned heads and tails become single-beat narrow transfers. Full bursts stay inside a 4 KB page and never exceed MAX_BEATS.
module dma_streamer #(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 64,
    parameter int MAX_BEATS  = 256
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dma_active_i,
    input  logic                  clear_dma_i,
    input  logic                  desc_valid_i,
    input  logic [ADDR_W-1:0]     desc_addr_i,
    input  logic [ADDR_W-1:0]     desc_num_bytes_i,
    output logic                  desc_ready_o,
    output logic [ADDR_W-1:0]     req_addr_o,
    output logic [7:0]            req_alen_o,
    output logic [2:0]            req_size_o,
    output logic [DATA_BYTES-1:0] req_strb_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic                  done_o
);
    localparam int                OFF_W      = $clog2(DATA_BYTES);
    localparam logic [ADDR_W-1:0] PAGE_BYTES = ADDR_W'(4096);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     rem_q, rem_d;

    logic                  abort;
    logic                  desc_accept;
    logic                  req_fire;
    logic [OFF_W-1:0]      off;
    logic                  narrow;
    logic [2:0]            nar_k;
    logic [ADDR_W-1:0]     full_beats, page_beats, beats;
    logic [ADDR_W-1:0]     req_bytes;
    logic [7:0]            alen;
    logic [2:0]            size;
    logic [DATA_BYTES-1:0] strb;

    // The lane mask is 2^k bytes wide, shifted up to the address offset.
    // The offset is 2^k-aligned, so the mask never runs past the bus width.
    function automatic logic [DATA_BYTES-1:0] narrow_strb(input logic [2:0] k,
                                                         input logic [OFF_W-1:0] o);
        logic [DATA_BYTES-1:0] ones;
        ones = (DATA_BYTES'(1) << (1 << k)) - DATA_BYTES'(1);
        return ones << o;
    endfunction

    assign abort       = clear_dma_i || !dma_active_i;
    assign desc_accept = desc_valid_i && desc_ready_o;
    assign req_fire    = (state_q == REQ) && req_ready_i;

    // Request formation from the current address / remaining-byte registers
    always_comb begin
        off    = addr_q[OFF_W-1:0];
        narrow = (off != '0) || (rem_q < ADDR_W'(DATA_BYTES));
        nar_k  = '0;
        for (int k = 0; k < OFF_W; k++) begin
            if ((rem_q >= (ADDR_W'(1) << k)) &&
                ((addr_q & ((ADDR_W'(1) << k) - ADDR_W'(1))) == '0))
                nar_k = 3'(k);
        end
        full_beats = rem_q >> OFF_W;
        page_beats = (PAGE_BYTES - ADDR_W'(addr_q[11:0])) >> OFF_W;
        beats      = full_beats;
        if (beats > ADDR_W'(MAX_BEATS)) beats = ADDR_W'(MAX_BEATS);
        if (beats > page_beats)         beats = page_beats;
        if (narrow) begin
            size      = nar_k;
            alen      = '0;
            req_bytes = ADDR_W'(1) << nar_k;
            strb      = narrow_strb(nar_k, off);
        end else begin
            size      = 3'(OFF_W);
            alen      = 8'(beats - ADDR_W'(1));
            req_bytes = beats << OFF_W;
            strb      = '1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        if (abort) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (desc_accept) begin
                    addr_d  = desc_addr_i;
                    rem_d   = desc_num_bytes_i;
                    state_d = (desc_num_bytes_i == '0) ? DONE : REQ;
                end
                REQ: if (req_fire) begin
                    addr_d = addr_q + req_bytes;
                    rem_d  = rem_q - req_bytes;
                    if (rem_q == req_bytes) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are gated by rstn so that they read zero while reset is held, regardless of dma_active_i.
    always_comb begin
        desc_ready_o = rstn && (state_q == IDLE) && dma_active_i && !clear_dma_i;
        req_valid_o  = rstn && (state_q == REQ);
        done_o       = rstn && (state_q == DONE);
        req_addr_o   = '0;
        req_alen_o   = '0;
        req_size_o   = '0;
        req_strb_o   = '0;
        if (req_valid_o) begin
            req_addr_o = addr_q;
            req_alen_o = alen;
            req_size_o = size;
            req_strb_o = strb;
        end
    end

endmodule

// File: tb/tb_dma_streamer.sv
// Directed bench for dma_streamer, built with DATA_BYTES=64 and MAX_BEATS=16.
module tb_dma_streamer;
    logic        clk = 1'b0;
    logic        rstn;
    logic        dma_active_i;
    logic        clear_dma_i;
    logic        desc_valid_i;
    logic [31:0] desc_addr_i;
    logic [31:0] desc_num_bytes_i;
    logic        desc_ready_o;
    logic [31:0] req_addr_o;
    logic [7:0]  req_alen_o;
    logic [2:0]  req_size_o;
    logic [63:0] req_strb_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        done_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] all1 = '1;

    dma_streamer #(.ADDR_W(32), .DATA_BYTES(64), .MAX_BEATS(16)) dut (
        .clk(clk), .rstn(rstn), .dma_active_i(dma_active_i), .clear_dma_i(clear_dma_i),
        .desc_valid_i(desc_valid_i), .desc_addr_i(desc_addr_i), .desc_num_bytes_i(desc_num_bytes_i),
        .desc_ready_o(desc_ready_o), .req_addr_o(req_addr_o), .req_alen_o(req_alen_o),
        .req_size_o(req_size_o), .req_strb_o(req_strb_o), .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [31:0] a, input logic [31:0] n);
        desc_addr_i      = a;
        desc_num_bytes_i = n;
        desc_valid_i     = 1'b1;
        tick();
        desc_valid_i     = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; dma_active_i = 1'b1; clear_dma_i = 1'b0; desc_valid_i = 1'b0;
        desc_addr_i = '0; desc_num_bytes_i = '0; req_ready_i = 1'b0;
        #12;
        n_tests++; if (desc_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_desc_ready: got %b want 0", desc_ready_o); end
        n_tests++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", req_valid_o); end
        n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done_o); end
        n_tests++; if (req_strb_o !== 64'h0) begin n_fail++; $display("FAIL rst_strb: got %h want 0", req_strb_o); end
        rstn = 1'b1;
        tick();
        n_tests++; if (desc_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_desc_ready: got %b want 1", desc_ready_o); end
    endtask

    task automatic test_single();
        req_ready_i = 1'b1;
        send_desc(32'h1000, 32'd128);
        n_tests++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", req_valid_o); end
        n_tests++; if (req_addr_o !== 32'h1000) begin n_fail++; $display("FAIL single_addr: got %h want 1000", req_addr_o); end
        n_tests++; if (req_alen_o !== 8'd1) begin n_fail++; $display("FAIL single_alen: got %0d want 1", req_alen_o); end
        n_tests++; if (req_size_o !== 3'd6) begin n_fail++; $display("FAIL single_size: got %0d want 6", req_size_o); end
        n_tests++; if (req_strb_o !== all1) begin n_fail++; $display("FAIL single_strb: got %h want all ones", req_strb_o); end
        n_tests++; if (desc_ready_o !== 1'b0) begin n_fail++; $display("FAIL single_ready_in_req: got %b want 0", desc_ready_o); end
        tick();
        n_tests++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done_o); end
        n_tests++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_done: got %b want 0", req_valid_o); end
        tick();
        n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0", done_o); end
    endtask

    task automatic test_page_split();
        logic [31:0] ea [2];
        logic [7:0]  el [2];
        ea = '{32'h0FC0, 32'h1000};
        el = '{8'd0, 8'd2};
        req_ready_i = 1'b1;
        send_desc(32'h0FC0, 32'd256);
        for (int i = 0; i < 2; i++) begin
            n_tests++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL split_valid[%0d]: got %b want 1", i, req_valid_o); end
            n_tests++; if (req_addr_o !== ea[i]) begin n_fail++; $display("FAIL split_addr[%0d]: got %h want %h", i, req_addr_o, ea[i]); end
            n_tests++; if (req_alen_o !== el[i]) begin n_fail++; $display("FAIL split_alen[%0d]: got %0d want %0d", i, req_alen_o, el[i]); end
            n_tests++; if (req_size_o !== 3'd6) begin n_fail++; $display("FAIL split_size[%0d]: got %0d want 6", i, req_size_o); end
            n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL split_early_done[%0d]: got %b want 0", i, done_o); end
            tick();
        end
        n_tests++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL split_done: got %b want 1", done_o); end
        tick();
    endtask

    task automatic test_unaligned();
        logic [31:0] ea [2];
        logic [2:0]  es [2];
        logic [63:0] eb [2];
        ea = '{32'h1003, 32'h1004};
        es = '{3'd0, 3'd2};
        eb = '{64'h8, 64'hF0};
        req_ready_i = 1'b1;
        send_desc(32'h1003, 32'd5);
        for (int i = 0; i < 2; i++) begin
            n_tests++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL unal_valid[%0d]: got %b want 1", i, req_valid_o); end
            n_tests++; if (req_addr_o !== ea[i]) begin n_fail++; $display("FAIL unal_addr[%0d]: got %h want %h", i, req_addr_o, ea[i]); end
            n_tests++; if (req_size_o !== es[i]) begin n_fail++; $display("FAIL unal_size[%0d]: got %0d want %0d", i, req_size_o, es[i]); end
            n_tests++; if (req_alen_o !== 8'd0) begin n_fail++; $display("FAIL unal_alen[%0d]: got %0d want 0", i, req_alen_o); end
            n_tests++; if (req_strb_o !== eb[i]) begin n_fail++; $display("FAIL unal_strb[%0d]: got %h want %h", i, req_strb_o, eb[i]); end
            tick();
        end
        n_tests++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL unal_done: got %b want 1", done_o); end
        tick();
    endtask

    task automatic test_stall_max_beats();
        logic [31:0] ea [2];
        ea = '{32'h0, 32'h400};
        req_ready_i = 1'b0;
        send_desc(32'h0, 32'd2048);
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 4; s++) begin
                if (s == 3) req_ready_i = 1'b1;
                n_tests++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d.%0d]: got %b want 1", i, s, req_valid_o); end
                n_tests++; if (req_addr_o !== ea[i]) begin n_fail++; $display("FAIL stall_addr[%0d.%0d]: got %h want %h", i, s, req_addr_o, ea[i]); end
                n_tests++; if (req_alen_o !== 8'd15) begin n_fail++; $display("FAIL stall_alen[%0d.%0d]: got %0d want 15", i, s, req_alen_o); end
                n_tests++; if (req_strb_o !== all1) begin n_fail++; $display("FAIL stall_strb[%0d.%0d]: got %h want all ones", i, s, req_strb_o); end
                tick();
                req_ready_i = 1'b0;
            end
        end
        n_tests++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b want 1", done_o); end
        tick();
    endtask

    task automatic test_zero_and_clear();
        req_ready_i = 1'b1;
        send_desc(32'h2000, 32'd0);
        n_tests++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done_o); end
        n_tests++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_valid: got %b want 0", req_valid_o); end
        tick();
        n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %b want 0", done_o); end
        send_desc(32'h0, 32'd4096);
        n_tests++; if (req_addr_o !== 32'h0) begin n_fail++; $display("FAIL clr_req0_addr: got %h want 0", req_addr_o); end
        tick();
        n_tests++; if (req_addr_o !== 32'h400) begin n_fail++; $display("FAIL clr_req1_addr: got %h want 400", req_addr_o); end
        clear_dma_i = 1'b1;
        tick();
        clear_dma_i = 1'b0;
        #1;
        n_tests++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", req_valid_o); end
        n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL clr_done: got %b want 0", done_o); end
        n_tests++; if (desc_ready_o !== 1'b1) begin n_fail++; $display("FAIL clr_desc_ready: got %b want 1", desc_ready_o); end
        tick();
        n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL clr_done_late: got %b want 0", done_o); end
        // Clear wins over a simultaneous descriptor.
        clear_dma_i = 1'b1;
        #1;
        n_tests++; if (desc_ready_o !== 1'b0) begin n_fail++; $display("FAIL clrdesc_ready: got %b want 0", desc_ready_o); end
        send_desc(32'h0, 32'd64);
        clear_dma_i = 1'b0;
        #1;
        n_tests++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL clrdesc_valid: got %b want 0", req_valid_o); end
        dma_active_i = 1'b0;
        #1;
        n_tests++; if (desc_ready_o !== 1'b0) begin n_fail++; $display("FAIL inactive_ready: got %b want 0", desc_ready_o); end
        dma_active_i = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        req_ready_i = 1'b0;
        send_desc(32'h0, 32'd4096);
        n_tests++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b want 1", req_valid_o); end
        #2 rstn = 1'b0;
        #1;
        n_tests++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", req_valid_o); end
        n_tests++; if (req_alen_o !== 8'd0) begin n_fail++; $display("FAIL arst_alen: got %0d want 0", req_alen_o); end
        n_tests++; if (req_size_o !== 3'd0) begin n_fail++; $display("FAIL arst_size: got %0d want 0", req_size_o); end
        n_tests++; if (req_strb_o !== 64'h0) begin n_fail++; $display("FAIL arst_strb: got %h want 0", req_strb_o); end
        n_tests++; if (desc_ready_o !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b want 0", desc_ready_o); end
        tick();
        rstn = 1'b1;
        #1;
        n_tests++; if (desc_ready_o !== 1'b1) begin n_fail++; $display("FAIL arst_release_ready: got %b want 1", desc_ready_o); end
        n_tests++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_release_valid: got %b want 0", req_valid_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_page_split();
        test_unaligned();
        test_stall_max_beats();
        test_zero_and_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/dma_streamer.md
Name: dma_streamer

Overview:
- Turns one linear DMA descriptor (start address, byte count) into a sequence of AXI4 INCR burst requests (addr, alen, size, strb, valid/ready) for the DMA AXI interface stage.
- Two instances exist, one for the read side and one for the write side. Both are driven by the DMA FSM.
- Handles unaligned heads and tails with single-beat narrow transfers, keeps every burst inside a 4 KB page, and caps burst length at MAX_BEATS.

Parameters:
- ADDR_W, 32, address and byte-count width.
- DATA_BYTES, 64, AXI data bus width in bytes (power of 2). Fixes full size = log2(DATA_BYTES) = 6.
- MAX_BEATS, 256, maximum beats per burst (1..256).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- dma_active_i  in  1  FSM in RUN. While low, the block is held in IDLE.
- clear_dma_i  in  1  synchronous abort to IDLE, highest priority.
- desc_valid_i  in  1  descriptor valid.
- desc_addr_i  in  ADDR_W  start byte address.
- desc_num_bytes_i  in  ADDR_W  total bytes to move.
- desc_ready_o  out  1  descriptor accepted when valid&&ready.
- req_addr_o  out  ADDR_W  burst start address.
- req_alen_o  out  8  AXI len (beats-1).
- req_size_o  out  3  AXI size.
- req_strb_o  out  DATA_BYTES  byte lanes valid on every beat of this request.
- req_valid_o  out  1  request valid.
- req_ready_i  in  1  request accepted (AXI address handshake done downstream).
- done_o  out  1  one-cycle pulse when the last request of a descriptor has been accepted.

Behaviour:
- Reset: state=IDLE. addr_ff=0, rem_ff=0. All outputs 0 except desc_ready_o, which is 0 because dma_active_i is don't-care during reset.
- States: IDLE, REQ, DONE.
- IDLE:
  - desc_ready_o = dma_active_i.
  - On accept, addr_ff<=desc_addr_i and rem_ff<=desc_num_bytes_i.
  - Next state is REQ, or DONE if num_bytes==0 (no request issued).
- REQ:
  - req_valid_o=1. All req fields are combinational from addr_ff/rem_ff, so the first request is valid the cycle after descriptor accept.
  - Fields stay stable while valid && !ready.
  - On valid&&ready: addr_ff+=bytes, rem_ff-=bytes. If rem_ff==bytes go to DONE, else stay in REQ; the next request is valid the following cycle with no bubble.
- DONE: done_o=1 for exactly one cycle, then IDLE. desc_ready_o=0 in REQ and DONE.
- Request formation, with off = addr_ff mod DATA_BYTES:
  - Narrow case (off!=0 or rem_ff<DATA_BYTES):
    - Pick the largest k < log2(DATA_BYTES) with 2^k<=rem_ff and addr_ff mod 2^k==0.
    - size=k, alen=0, bytes=2^k, strb=((1<<2^k)-1)<<off.
  - Full case:
    - beats = min(rem_ff/DATA_BYTES, MAX_BEATS, (4096-(addr_ff mod 4096))/DATA_BYTES).
    - size=log2(DATA_BYTES), alen=beats-1, bytes=beats*DATA_BYTES, strb=all ones.
  - No request may cross a 4 KB boundary. Narrow transfers never cross it by construction.
- Arithmetic: rem_ff is unsigned. Any computation that overflows ADDR_W is truncated. Address wrap past 2^ADDR_W is not supported; the descriptor must not wrap.
- Abort: clear_dma_i=1 or dma_active_i=0 in any state:
  - next state IDLE, rem_ff<=0, req_valid_o drops the next cycle, no done_o.
  - This also applies mid-handshake; a request accepted in the same cycle still counts downstream.
- Simultaneous desc_valid and clear in IDLE: clear wins, descriptor not accepted.

Test Plan:
- addr=0x1000, bytes=128, ready always 1 -> one req: addr 0x1000, alen 1, size 6, strb all ones. done_o pulses 2 cycles after accept.
- addr=0x0FC0, bytes=256 -> req0 0x0FC0 alen 0 size 6; req1 0x1000 alen 2 size 6 (4 KB split). One done.
- addr=0x1003, bytes=5 -> req0 0x1003 size 0 strb 0x8; req1 0x1004 size 2 strb 0xF0. One done.
- MAX_BEATS=16, addr=0x0, bytes=2048, req_ready held low 3 cycles per request -> two reqs: 0x0 and 0x400, each alen 15, with fields stable while stalled.
- bytes=0 -> no req_valid, done_o one cycle after accept. Then clear_dma_i asserted in REQ mid-transfer (0x0, 4096 bytes, after first accept) -> valid low next cycle, IDLE, no done_o, desc_ready_o=1.
- Reset asserted asynchronously in REQ -> all outputs 0 immediately. After release with dma_active_i=1, desc_ready_o=1.
